// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: parallel load, serial shifts, rotates,
// and a counted burst engine that repeats one shift/rotate step with busy/done status.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] dout,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_SHL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // One step of the selected operation; reserved codes and hold keep the value.
  function automatic logic [WIDTH-1:0] step_fn(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] ld,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    case (m)
      MODE_HOLD: r = d;
      MODE_LOAD: r = ld;
      MODE_SHR:  r = {sl, d[WIDTH-1:1]};
      MODE_SHL:  r = {d[WIDTH-2:0], sr};
      MODE_ROR:  r = {d[0], d[WIDTH-1:1]};
      MODE_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
      default:   r = d;
    endcase
    return r;
  endfunction

  // Only shift and rotate codes may be repeated by the burst engine.
  function automatic logic burst_mode_fn(input logic [2:0] m);
    logic r;
    case (m)
      MODE_SHR: r = 1'b1;
      MODE_SHL: r = 1'b1;
      MODE_ROR: r = 1'b1;
      MODE_ROL: r = 1'b1;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

  state_t           state_r, state_s;
  logic [WIDTH-1:0] dout_r,  dout_s;
  logic [2:0]       mode_r,  mode_s;
  logic [CNT_W-1:0] cnt_r,   cnt_s;
  logic             done_r,  done_s;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      dout_r  <= {WIDTH{1'b0}};
      mode_r  <= MODE_HOLD;
      cnt_r   <= CNT_ZERO;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      dout_r  <= dout_s;
      mode_r  <= mode_s;
      cnt_r   <= cnt_s;
      done_r  <= done_s;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_s = state_r;
    dout_s  = dout_r;
    mode_s  = mode_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && burst_mode_fn(mode)) begin
          // A zero-length burst reports completion without stepping.
          if (count != CNT_ZERO) begin
            state_s = BUSY;
            mode_s  = mode;
            cnt_s   = count;
          end else begin
            done_s  = 1'b1;
          end
        end else if (en) begin
          dout_s = step_fn(mode, dout_r, din, sin_l, sin_r);
        end else begin
          dout_s = dout_r;
        end
      end
      BUSY: begin
        // Serial inputs stream in live; only the latched mode matters here.
        dout_s = step_fn(mode_r, dout_r, din, sin_l, sin_r);
        cnt_s  = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output mapping straight from registers.
  always_comb begin
    dout   = dout_r;
    sout_l = dout_r[WIDTH-1];
    sout_r = dout_r[0];
    busy   = (state_r == BUSY);
    done   = done_r;
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: a behavioural model pushes expected
// outputs per driven cycle, popped and compared after the clock edge.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] din;
  logic             sin_l;
  logic             sin_r;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] dout;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;

  int total_cnt;
  int bad_cnt;

  univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .din    (din),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .start  (start),
    .count  (count),
    .dout   (dout),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {dout, busy, done} per cycle
  logic [WIDTH+1:0] exp_q[$];

  logic [WIDTH-1:0] m_dout;
  logic             m_busy;
  logic             m_done;
  logic [2:0]       m_mode;
  int               m_left;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got !== want) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_step(input logic [2:0] m, input logic [WIDTH-1:0] d,
                                                   input logic [WIDTH-1:0] di, input logic sl,
                                                   input logic sr);
    logic [WIDTH-1:0] top_l;
    logic [WIDTH-1:0] top_d;
    top_l = {sl, {(WIDTH-1){1'b0}}};
    top_d = {d[0], {(WIDTH-1){1'b0}}};
    case (m)
      3'd1:    return di;
      3'd2:    return (d >> 1) | top_l;
      3'd3:    return (d << 1) | {{(WIDTH-1){1'b0}}, sr};
      3'd4:    return (d >> 1) | top_d;
      3'd5:    return (d << 1) | {{(WIDTH-1){1'b0}}, d[WIDTH-1]};
      default: return d;
    endcase
  endfunction

  // Drive one cycle, advance the model, then compare after the edge.
  task automatic cyc(input logic r, input logic e, input logic [2:0] md, input logic [WIDTH-1:0] di,
                     input logic sl, input logic sr, input logic st, input logic [CNT_W-1:0] cn);
    logic [WIDTH+1:0] exp_v;
    rst = r; en = e; mode = md; din = di; sin_l = sl; sin_r = sr; start = st; count = cn;
    if (r) begin
      m_dout = '0; m_busy = 1'b0; m_done = 1'b0; m_mode = 3'd0; m_left = 0;
    end else if (m_busy) begin
      m_dout = model_step(m_mode, m_dout, di, sl, sr);
      m_left = m_left - 1;
      m_busy = (m_left != 0);
      m_done = (m_left == 0);
    end else begin
      m_done = 1'b0;
      if (st && md >= 3'd2 && md <= 3'd5) begin
        if (cn != 0) begin
          m_busy = 1'b1; m_mode = md; m_left = int'(cn);
        end else begin
          m_done = 1'b1;
        end
      end else if (e) begin
        m_dout = model_step(md, m_dout, di, sl, sr);
      end
    end
    exp_q.push_back({m_dout, m_busy, m_done});
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    check_val("dout",   32'(dout),   32'(exp_v[WIDTH+1:2]));
    check_val("busy",   32'(busy),   32'(exp_v[1]));
    check_val("done",   32'(done),   32'(exp_v[0]));
    check_val("sout_l", 32'(sout_l), 32'(exp_v[WIDTH+1]));
    check_val("sout_r", 32'(sout_r), 32'(exp_v[2]));
  endtask

  task automatic idle_cyc(input logic sr);
    cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, sr, 1'b0, 4'd0);
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    cyc(1'b0, 1'b1, 3'd1, v, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    total_cnt = 0; bad_cnt = 0;
    m_dout = '0; m_busy = 1'b0; m_done = 1'b0; m_mode = 3'd0; m_left = 0;

    // Reset then load
    cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    check_val("rst_dout", 32'(dout), 32'h0);
    load(8'b1011_0010);
    check_val("load_val", 32'(dout), 32'hB2);

    // Single-step shifts
    cyc(1'b0, 1'b1, 3'd2, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0);
    check_val("shr_val", 32'(dout), 32'hD9);
    cyc(1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    check_val("shl_val", 32'(dout), 32'hB2);

    // Burst rotate left by 3, then by 8
    load(8'b1000_0001);
    cyc(1'b0, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3);
    check_val("rol_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 3; i++) idle_cyc(1'b0);
    check_val("rol3_val", 32'(dout), 32'h0C);
    check_val("rol3_done", 32'(done), 32'h1);
    idle_cyc(1'b0);
    cyc(1'b0, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0, 1'b1, 4'd8);
    for (int i = 0; i < 9; i++) idle_cyc(1'b0);
    check_val("rol8_val", 32'(dout), 32'h0C);

    // Burst shift left with streamed sin_r, noise on ignored inputs
    load(8'h00);
    cyc(1'b0, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0, 1'b1, 4'd4);
    cyc(1'b0, 1'b1, 3'd1, 8'hFF, 1'b0, 1'b1, 1'b1, 4'd9);
    cyc(1'b0, 1'b0, 3'd4, 8'h5A, 1'b1, 1'b0, 1'b0, 4'd1);
    cyc(1'b0, 1'b1, 3'd0, 8'hA5, 1'b0, 1'b1, 1'b1, 4'd2);
    cyc(1'b0, 1'b1, 3'd1, 8'h33, 1'b1, 1'b1, 1'b0, 4'd0);
    check_val("stream_val", 32'(dout), 32'h0B);
    idle_cyc(1'b0);

    // Edge cases: zero count, start with load mode, reserved mode
    cyc(1'b0, 1'b0, 3'd2, 8'h00, 1'b1, 1'b0, 1'b1, 4'd0);
    check_val("zero_done", 32'(done), 32'h1);
    check_val("zero_busy", 32'(busy), 32'h0);
    cyc(1'b0, 1'b0, 3'd1, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd5);
    check_val("ldstart_val", 32'(dout), 32'h0B);
    cyc(1'b0, 1'b1, 3'd6, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd0);
    check_val("rsvd_hold", 32'(dout), 32'h0B);

    // Reset mid-burst, then a fresh burst
    load(8'hA5);
    cyc(1'b0, 1'b0, 3'd2, 8'h00, 1'b1, 1'b0, 1'b1, 4'd10);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    check_val("abort_dout", 32'(dout), 32'h0);
    idle_cyc(1'b0);
    check_val("abort_nodone", 32'(done), 32'h0);
    load(8'h96);
    cyc(1'b0, 1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5);
    for (int i = 0; i < 5; i++) idle_cyc(1'b0);
    check_val("ror5_val", 32'(dout), 32'hB4);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0), 1'($urandom), 3'($urandom), 8'($urandom),
          1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
